fifo_rd_prefetch: RTL and testbench



---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_rd_prefetch.sv | 87 ++++++++
 tb/tb_fifo_rd_prefetch.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Constants shared between the async FIFO and its read-side prefetch consumer.
package fifo_pkg;

    localparam int DATASIZE = 8;

    localparam logic [1:0] LVL_EMPTY = 2'd0;
    localparam logic [1:0] LVL_ONE   = 2'd1;
    localparam logic [1:0] LVL_FULL  = 2'd2;

endpackage

// File: rtl/fifo_rd_prefetch.sv
// Pops the async FIFO into a 2-entry buffer and streams bytes out; PREFETCH_CNT_EN adds tx_count_o.
// Latency: a byte popped in cycle N is presented with m_valid_o in cycle N+1; 1 byte/cycle sustained.
// Backpressure: m_ready_i low fills the buffer to 2, then rinc_o stops; rinc_o never depends on m_ready_i.
module fifo_rd_prefetch
    import fifo_pkg::*;
#(
    parameter int DATASIZE = fifo_pkg::DATASIZE
`ifdef PREFETCH_CNT_EN
   ,parameter int CNTSIZE  = 8
`endif
) (
    input  logic                rclk_i,
    input  logic                rrst_ni,
    input  logic                rempty_i,
    input  logic [DATASIZE-1:0] rdata_i,
    output logic                rinc_o,
    input  logic                flush_i,
    output logic                m_valid_o,
    output logic [DATASIZE-1:0] m_data_o,
    input  logic                m_ready_i,
    output logic [1:0]          level_o
`ifdef PREFETCH_CNT_EN
   ,output logic [CNTSIZE-1:0]  tx_count_o
`endif
);

    logic [1:0]          level_q, level_d;
    logic [DATASIZE-1:0] entry0_q, entry0_d;
    logic [DATASIZE-1:0] entry1_q, entry1_d;
    logic                fire;

    // rrst_ni gate keeps the FIFO pointer untouched while the read domain is held in reset.
    assign rinc_o    = rrst_ni & ~rempty_i & ~flush_i & (level_q != LVL_FULL);
    assign m_valid_o = (level_q != LVL_EMPTY) & ~flush_i;
    assign fire      = m_valid_o & m_ready_i;
    assign m_data_o  = entry0_q;
    assign level_o   = level_q;

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        level_d  = level_q + {1'b0, rinc_o} - {1'b0, fire};
        if (flush_i) begin
            level_d = LVL_EMPTY;
        end else begin
            case (level_q)
                LVL_EMPTY: if (rinc_o) entry0_d = rdata_i;
                LVL_ONE: begin
                    if (rinc_o && fire)  entry0_d = rdata_i;
                    if (rinc_o && !fire) entry1_d = rdata_i;
                end
                LVL_FULL:  if (fire) entry0_d = entry1_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge rclk_i or negedge rrst_ni) begin
        if (!rrst_ni) begin
            level_q  <= LVL_EMPTY;
            entry0_q <= '0;
            entry1_q <= '0;
        end else begin
            level_q  <= level_d;
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
        end
    end

`ifdef PREFETCH_CNT_EN
    logic [CNTSIZE-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush_i)   cnt_d = '0;
        else if (fire) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge rclk_i or negedge rrst_ni) begin
        if (!rrst_ni) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign tx_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Randomized bench for fifo_rd_prefetch against a queue-level model of FIFO, buffer and stream.
module tb_fifo_rd_prefetch;

    localparam int DW = 8;
`ifdef PREFETCH_CNT_EN
    localparam int CW = 4;
`endif

    logic          rclk_i = 1'b0;
    logic          rrst_ni = 1'b0;
    logic          rempty_i = 1'b1;
    logic [DW-1:0] rdata_i = '0;
    logic          rinc_o;
    logic          flush_i = 1'b0;
    logic          m_valid_o;
    logic [DW-1:0] m_data_o;
    logic          m_ready_i = 1'b0;
    logic [1:0]    level_o;
`ifdef PREFETCH_CNT_EN
    logic [CW-1:0] tx_count_o;
`endif

    fifo_rd_prefetch #(
        .DATASIZE (DW)
`ifdef PREFETCH_CNT_EN
       ,.CNTSIZE  (CW)
`endif
    ) dut (
        .rclk_i    (rclk_i),
        .rrst_ni   (rrst_ni),
        .rempty_i  (rempty_i),
        .rdata_i   (rdata_i),
        .rinc_o    (rinc_o),
        .flush_i   (flush_i),
        .m_valid_o (m_valid_o),
        .m_data_o  (m_data_o),
        .m_ready_i (m_ready_i),
        .level_o   (level_o)
`ifdef PREFETCH_CNT_EN
       ,.tx_count_o(tx_count_o)
`endif
    );

    always #5 rclk_i = ~rclk_i;

    int total = 0;
    int bad   = 0;

    // Model state: the FIFO contents, the bytes held by the prefetcher, the byte last at the head.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] buf_q[$];
    logic [DW-1:0] head_m = '0;
    int            cnt_m  = 0;
    int            sent_n = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check 1ns later, update the model across the posedge.
    task automatic cycle(input logic rdy, input logic fl);
        logic exp_rinc, exp_valid, exp_fire;
        m_ready_i = rdy;
        flush_i   = fl;
        rempty_i  = (fifo_q.size() == 0);
        rdata_i   = rempty_i ? DW'($urandom) : fifo_q[0];
        #1;
        exp_rinc  = (fifo_q.size() != 0) && !fl && (buf_q.size() < 2);
        exp_valid = (buf_q.size() != 0) && !fl;
        exp_fire  = exp_valid && rdy;
        chk("rinc", rinc_o, exp_rinc);
        chk("valid", m_valid_o, exp_valid);
        chk("data", m_data_o, head_m);
        chk("level", level_o, buf_q.size());
        chk("rinc_while_empty", rinc_o & rempty_i, 0);
`ifdef PREFETCH_CNT_EN
        chk("count", tx_count_o, cnt_m % (1 << CW));
`endif
        @(posedge rclk_i);
        if (fl) begin
            buf_q.delete();
            cnt_m = 0;
        end else begin
            if (exp_fire) begin
                void'(buf_q.pop_front());
                cnt_m++;
                sent_n++;
            end
            if (exp_rinc) buf_q.push_back(fifo_q.pop_front());
        end
        if (buf_q.size() != 0) head_m = buf_q[0];
        @(negedge rclk_i);
    endtask

    initial begin
        // Reset: outputs idle and no pop even though the FIFO claims data.
        rempty_i = 1'b0;
        rdata_i  = 8'h5A;
        #1;
        chk("rst_rinc", rinc_o, 0);
        chk("rst_valid", m_valid_o, 0);
        chk("rst_data", m_data_o, 0);
        chk("rst_level", level_o, 0);
        @(negedge rclk_i);
        @(negedge rclk_i);
        rrst_ni = 1'b1;

        // Short stream, always ready.
        fifo_q = '{8'hA1, 8'hB2, 8'hC3};
        repeat (6) cycle(1'b1, 1'b0);
        chk("t1_drained", sent_n, 3);

        // Stall with 5 bytes queued, then release.
        fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        repeat (5) cycle(1'b0, 1'b0);
        chk("t2_fifo_left", fifo_q.size(), 3);
        chk("t2_level_full", level_o, 2);
        chk("t2_head", m_data_o, 8'h01);
        repeat (7) cycle(1'b1, 1'b0);
        chk("t2_drained", sent_n, 8);

        // 256 bytes with random readiness.
        for (int i = 0; i < 256; i++) fifo_q.push_back(DW'(i));
        for (int c = 0; c < 2000 && (fifo_q.size() != 0 || buf_q.size() != 0); c++)
            cycle(1'($urandom_range(0, 1)), 1'b0);
        chk("t3_drained", sent_n, 264);

        // Flush with two buffered bytes; the next FIFO byte follows.
        fifo_q = '{8'h11, 8'h22, 8'h33};
        repeat (3) cycle(1'b0, 1'b0);
        chk("t4_level_full", level_o, 2);
        cycle(1'b0, 1'b1);
        chk("t4_level_after", level_o, 0);
        repeat (3) cycle(1'b1, 1'b0);
        chk("t4_fifo_empty", fifo_q.size(), 0);

        // Asynchronous reset in the middle of streaming at level 1.
        repeat (20) fifo_q.push_back(DW'($urandom));
        repeat (4) cycle(1'b1, 1'b0);
        chk("t5_level_one", level_o, 1);
        #2;
        rrst_ni = 1'b0;
        #1;
        chk("t5_valid", m_valid_o, 0);
        chk("t5_level", level_o, 0);
        chk("t5_data", m_data_o, 0);
        chk("t5_rinc", rinc_o, 0);
`ifdef PREFETCH_CNT_EN
        chk("t5_count", tx_count_o, 0);
`endif
        @(negedge rclk_i);
        rrst_ni = 1'b1;
        fifo_q.delete();
        buf_q.delete();
        head_m = '0;
        cnt_m  = 0;

`ifdef PREFETCH_CNT_EN
        // Counter wraps modulo 16 and clears on flush.
        for (int i = 0; i < 18; i++) fifo_q.push_back(DW'(8'h40 + i));
        repeat (20) cycle(1'b1, 1'b0);
        chk("t6_wrap", tx_count_o, 2);
        cycle(1'b1, 1'b1);
        chk("t6_flush", tx_count_o, 0);
`endif

        // Post-reset sanity stream.
        fifo_q = '{8'hDE, 8'hAD};
        repeat (4) cycle(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
